pc_fetch_sequencer: RTL and testbench

Fetch-stage controller that owns the program counter and sequences instruction fetch in the 5-stage pipeline. It issues one request at a time to instruction memory and advances the PC by 4 or redirects it to a resolved branch target. It hands each fetched instruction to the IF/ID register, honouring hazard-unit stalls. It squashes any fetch made obsolete by a redirect.

---
 rtl/pc_seq_pkg.sv | 24 ++
 rtl/pc_fetch_sequencer_pc_reg64.sv | 32 +++
 rtl/pc_fetch_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// The HALT state only exists when PCSEQ_MISALIGN_TRAP_EN is defined.
package pc_seq_pkg;

  localparam int PC_W        = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_SQUASH
`ifdef PCSEQ_MISALIGN_TRAP_EN
    , ST_HALT
`endif
  } fetch_state_e;

  // Sequential successor of a PC; wraps modulo 2^64 by construction.
  function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_pc_reg64.sv
// 64-bit register with load enable and asynchronous active-high reset
// to a parameterised value. Used for the live PC and the delivered PC.
module pc_reg64
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [PC_W-1:0] d,
  output logic [PC_W-1:0] q
);

  logic [PC_W-1:0] val_q;
  logic [PC_W-1:0] val_d;

  // Take the new value only when loaded, otherwise hold.
  always_comb begin
    val_d = val_q;
    if (load) val_d = d;
  end

  // Storage with asynchronous reset to the configured value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) val_q <= RESET_PC;
    else       val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues one instruction fetch at a
// time, hands words to IF/ID under stall control and squashes fetches
// made obsolete by a redirect. All outputs are registered.
// Optional feature macro: PCSEQ_MISALIGN_TRAP_EN (misaligned redirect
// target raises sticky misalign and halts fetch until reset).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_REQ    | issue a request for pc on the next edge
// ST_WAIT   | request outstanding, waiting for imem_valid
// ST_HOLD   | word captured while IF/ID stalled, waiting for stall=0
// ST_SQUASH | obsolete request outstanding, its response is dropped
// ST_HALT   | misaligned redirect seen; terminal until reset (macro only)
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               if_valid,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               flush,
  output logic               misalign
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic               pc_load;
  logic               imem_req_q, imem_req_d;
  logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [INSTR_W-1:0] hold_q, hold_d;
  logic               flush_q, flush_d;
  logic               deliver;
  logic [INSTR_W-1:0] deliver_word;
`ifdef PCSEQ_MISALIGN_TRAP_EN
  logic               misalign_q, misalign_d;
`endif

  // Next-state, next-PC mux and registered-output values.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_req_d   = 1'b0;
    imem_addr_d  = imem_addr_q;
    hold_d       = hold_q;
    flush_d      = 1'b0;
    deliver      = 1'b0;
    deliver_word = imem_data;
`ifdef PCSEQ_MISALIGN_TRAP_EN
    misalign_d   = misalign_q;
`endif

    case (state_q)
      ST_REQ: begin
        imem_req_d  = 1'b1;
        imem_addr_d = pc_q;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_valid) begin
          if (!stall) begin
            deliver = 1'b1;
            state_d = ST_REQ;
          end else begin
            hold_d  = imem_data;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          deliver      = 1'b1;
          deliver_word = hold_q;
          state_d      = ST_REQ;
        end
      end
      ST_SQUASH: begin
        if (imem_valid) state_d = ST_REQ;
      end
      default: ;
    endcase

    if (deliver) pc_d = next_seq_pc(pc_q);

    // Redirect overrides delivery. A request issued on this same edge from
    // ST_REQ still goes out, so its response must be squashed. In ST_SQUASH
    // a response arriving together with the redirect is consumed, so the
    // state still returns to ST_REQ rather than waiting for a second one.
    if (redirect) begin
      deliver = 1'b0;
      pc_d    = redirect_pc;
      flush_d = 1'b1;
      hold_d  = hold_q;
      case (state_q)
        ST_REQ:  state_d = ST_SQUASH;
        ST_WAIT: state_d = imem_valid ? ST_REQ : ST_SQUASH;
        ST_HOLD: state_d = ST_REQ;
        default: ;
      endcase
`ifdef PCSEQ_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d  = 1'b1;
        state_d     = ST_HALT;
        imem_req_d  = 1'b0;
        imem_addr_d = imem_addr_q;
      end
`endif
    end

    pc_load    = deliver | redirect;
    if_valid_d = deliver;
    if_instr_d = deliver ? deliver_word : if_instr_q;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_REQ;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      hold_q      <= '0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      hold_q      <= hold_d;
      flush_q     <= flush_d;
    end
  end

`ifdef PCSEQ_MISALIGN_TRAP_EN
  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  pc_reg64 #(.RESET_PC(RESET_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_d),
    .q     (pc_q)
  );

  // The PC register still holds the fetched address at delivery time.
  pc_reg64 #(.RESET_PC('0)) u_if_pc (
    .clk   (clk),
    .reset (reset),
    .load  (deliver),
    .d     (pc_q),
    .q     (if_pc)
  );

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign flush     = flush_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: memory responder plus a transaction-level
// reference model (outstanding fetch, pending word, expected next PC).
module tb_pc_fetch_sequencer;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_data = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
  logic        misalign;

  int n_cmp = 0;
  int n_err = 0;
  int ncyc  = 0;

  // reference model state
  bit          os_live, os_obs;
  logic [63:0] os_pc;
  bit          pend_live;
  logic [63:0] pend_pc;
  logic [31:0] pend_word;
  logic [63:0] exp_pc, exp_req_addr, exp_if_pc;
  logic [31:0] exp_if_instr;
  bit          exp_if_valid, exp_flush, req_overlap;
  int          mem_cnt;
  int          lat_fixed;
  bit          force_en;
  logic [31:0] force_word;

  pc_fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .flush       (flush),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  task automatic model_init();
    os_live = 0; os_obs = 0; os_pc = '0;
    pend_live = 0; pend_pc = '0; pend_word = '0;
    exp_pc = RESET_PC; exp_req_addr = '0;
    exp_if_pc = '0; exp_if_instr = '0;
    exp_if_valid = 0; exp_flush = 0; req_overlap = 0;
    mem_cnt = 0; force_en = 0; force_word = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; imem_data = '0;
    model_init();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock: inputs present now are consumed at the next rising edge;
  // the model then predicts what that edge must produce.
  task automatic cycle();
    logic s, r, v;
    logic [63:0] rp, pre_pc;
    logic [31:0] d;
    s = stall; r = redirect; v = imem_valid; rp = redirect_pc; d = imem_data;
    @(posedge clk);
    @(negedge clk);
    ncyc++;
    pre_pc = exp_pc;
    exp_if_valid = 0; exp_flush = 0; req_overlap = 0;
    if (v && os_live) begin
      os_live = 0;
      if (!os_obs && !r) begin
        pend_live = 1; pend_pc = os_pc; pend_word = d;
      end
    end
    if (!r && pend_live && !s) begin
      exp_if_valid = 1; exp_if_pc = pend_pc; exp_if_instr = pend_word;
      exp_pc = pend_pc + 64'd4; pend_live = 0;
    end
    if (imem_req) begin
      req_overlap = os_live || pend_live;
      exp_req_addr = pre_pc;
      os_live = 1; os_obs = 0; os_pc = pre_pc;
      mem_cnt = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
    end
    if (r) begin
      exp_flush = 1; pend_live = 0; exp_pc = rp;
      if (os_live) os_obs = 1;
    end
    imem_valid = 1'b0;
    if (!imem_req && mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_valid = 1'b1;
        imem_data  = force_en ? force_word : $urandom;
        force_en   = 0;
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({imem_req, imem_addr, flush, misalign} !== 67'd0)
      $display("FAIL reset_req_group: got req=%b addr=%h flush=%b mis=%b want all 0",
               imem_req, imem_addr, flush, misalign);
    n_cmp++;
    if ({if_valid, if_pc, if_instr} !== 97'd0)
      $display("FAIL reset_if_group: got v=%b pc=%h instr=%h want all 0", if_valid, if_pc, if_instr);
    lat_fixed = 1;
    do_reset();
    cycle();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_err++;
      $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    int k, last, req_cyc;
    do_reset();
    lat_fixed = 1;
    cycle();
    req_cyc = ncyc; k = 0; last = 0;
    for (int i = 0; i < 20 && k < 4; i++) begin
      cycle();
      if (if_valid) begin
        n_cmp++;
        if (if_pc !== 64'(k * 4)) begin
          n_err++; $display("FAIL seq_pc: got %h want %h", if_pc, 64'(k * 4));
        end
        n_cmp++;
        if (k == 0 && ncyc - req_cyc != 2) begin
          n_err++; $display("FAIL seq_latency: got %0d cycles want 2", ncyc - req_cyc);
        end else if (k > 0 && ncyc - last != 3) begin
          n_err++; $display("FAIL seq_spacing: got %0d cycles want 3", ncyc - last);
        end
        last = ncyc; k++;
      end
    end
    n_cmp++;
    if (k != 4) begin
      n_err++; $display("FAIL seq_count: got %0d deliveries want 4", k);
    end
  endtask

  task automatic test_stall();
    bit found = 0;
    do_reset();
    lat_fixed = 1;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (imem_req && imem_addr == 64'd8) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL stall_req8: got no request to 8 want one within 30 cycles");
      return;
    end
    force_en = 1; force_word = 32'hDEADBEEF;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++;
      if (if_valid !== 1'b0) begin
        n_err++; $display("FAIL stall_no_valid: got if_valid=%b want 0", if_valid);
      end
    end
    stall = 1'b0;
    cycle();
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 64'd8 || if_instr !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL stall_release: got v=%b pc=%h instr=%h want v=1 pc=8 instr=deadbeef",
               if_valid, if_pc, if_instr);
    end
    cycle();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 64'd12) begin
      n_err++; $display("FAIL stall_next_req: got req=%b addr=%h want req=1 addr=c", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    bit found = 0, bad = 0, got = 0;
    do_reset();
    lat_fixed = 3;
    cycle();
    cycle();
    redirect = 1'b1; redirect_pc = 64'h100;
    cycle();
    redirect = 1'b0;
    n_cmp++;
    if (flush !== 1'b1 || if_valid !== 1'b0) begin
      n_err++; $display("FAIL rdw_flush: got flush=%b v=%b want flush=1 v=0", flush, if_valid);
    end
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (if_valid || flush) bad = 1;
      if (imem_req) found = 1;
    end
    n_cmp++;
    if (bad || !found || imem_addr !== 64'h100) begin
      n_err++;
      $display("FAIL rdw_next_req: got stray=%b found=%b addr=%h want stray=0 found=1 addr=100",
               bad, found, imem_addr);
    end
    lat_fixed = 1;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (if_valid) got = 1;
    end
    n_cmp++;
    if (!got || if_pc !== 64'h100 || if_instr !== exp_if_instr) begin
      n_err++;
      $display("FAIL rdw_deliver: got v=%b pc=%h instr=%h want v=1 pc=100 instr=%h",
               got, if_pc, if_instr, exp_if_instr);
    end
  endtask

  task automatic test_redirect_same_cycle();
    bit found = 0, bad = 0;
    do_reset();
    lat_fixed = 1;
    cycle();
    cycle();
    redirect = 1'b1; redirect_pc = 64'h200;
    cycle();
    redirect = 1'b0;
    n_cmp++;
    if (flush !== 1'b1 || if_valid !== 1'b0) begin
      n_err++; $display("FAIL rds_flush: got flush=%b v=%b want flush=1 v=0", flush, if_valid);
    end
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (if_valid) bad = 1;
      if (imem_req) found = 1;
    end
    n_cmp++;
    if (bad || !found || imem_addr !== 64'h200) begin
      n_err++;
      $display("FAIL rds_next_req: got stray=%b found=%b addr=%h want stray=0 found=1 addr=200",
               bad, found, imem_addr);
    end
  endtask

  task automatic test_wrap();
    bit got = 0, found = 0;
    do_reset();
    lat_fixed = 1;
    cycle();
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (if_valid) got = 1;
    end
    n_cmp++;
    if (!got || if_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_err++; $display("FAIL wrap_deliver: got v=%b pc=%h want v=1 pc=fffffffffffffffc", got, if_pc);
    end
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (imem_req) found = 1;
    end
    n_cmp++;
    if (!found || imem_addr !== 64'h0) begin
      n_err++; $display("FAIL wrap_next_req: got found=%b addr=%h want found=1 addr=0", found, imem_addr);
    end
  endtask

  task automatic test_async_reset();
    bit got = 0, found = 0;
    do_reset();
    lat_fixed = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (if_valid && if_pc == 64'd4) got = 1;
    end
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (imem_req) found = 1;
    end
    n_cmp++;
    if (!got || !found) begin
      n_err++; $display("FAIL arst_setup: got deliver4=%b req=%b want both 1", got, found);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({imem_req, imem_addr, if_valid, if_pc, if_instr, flush, misalign} !== 164'd0) begin
      n_err++;
      $display("FAIL arst_clear: got req=%b addr=%h v=%b pc=%h instr=%h flush=%b want all 0",
               imem_req, imem_addr, if_valid, if_pc, if_instr, flush);
    end
    do_reset();
    cycle();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_err++; $display("FAIL arst_restart: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    int idle = 0;
    do_reset();
    lat_fixed = 0;
    for (int i = 0; i < 600; i++) begin
      stall    = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | ({32'd0, $urandom} & 64'hC);
      cycle();
      n_cmp++;
      if (if_valid !== exp_if_valid || if_pc !== exp_if_pc || if_instr !== exp_if_instr) begin
        n_err++;
        $display("FAIL rnd_if @%0d: got v=%b pc=%h instr=%h want v=%b pc=%h instr=%h",
                 ncyc, if_valid, if_pc, if_instr, exp_if_valid, exp_if_pc, exp_if_instr);
      end
      n_cmp++;
      if (flush !== exp_flush || misalign !== 1'b0) begin
        n_err++;
        $display("FAIL rnd_flush @%0d: got flush=%b mis=%b want flush=%b mis=0", ncyc, flush, misalign, exp_flush);
      end
      if (imem_req) begin
        n_cmp++;
        if (imem_addr !== exp_req_addr || req_overlap) begin
          n_err++;
          $display("FAIL rnd_req @%0d: got addr=%h overlap=%b want addr=%h overlap=0",
                   ncyc, imem_addr, req_overlap, exp_req_addr);
        end
      end
      idle = (imem_req || if_valid) ? 0 : idle + 1;
      n_cmp++;
      if (idle > 40) begin
        n_err++; $display("FAIL rnd_progress @%0d: got %0d idle cycles want at most 40", ncyc, idle);
        idle = 0;
      end
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

`ifdef PCSEQ_MISALIGN_TRAP_EN
  task automatic test_misalign();
    bit bad = 0;
    do_reset();
    lat_fixed = 1;
    cycle();
    redirect = 1'b1; redirect_pc = 64'h102;
    cycle();
    redirect = 1'b0;
    n_cmp++;
    if (misalign !== 1'b1 || flush !== 1'b1) begin
      n_err++; $display("FAIL mis_set: got mis=%b flush=%b want mis=1 flush=1", misalign, flush);
    end
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (imem_req || if_valid || !misalign) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_err++; $display("FAIL mis_halt: got activity_or_clear=%b want 0", bad);
    end
    do_reset();
    n_cmp++;
    if (misalign !== 1'b0) begin
      n_err++; $display("FAIL mis_clear: got mis=%b want 0", misalign);
    end
    cycle();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_err++; $display("FAIL mis_restart: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask
`endif

  initial begin
    model_init();
    lat_fixed = 1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_wrap();
    test_async_reset();
    test_random();
`ifdef PCSEQ_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion want finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
